// File: rtl/glitch_free_func_if.sv
// Handshake bundle for glitch_free_func.
//   en   : filter enable
//   byp  : bypass qualification (effective only with en=1)
//   in   : N asynchronous function inputs
//   f    : registered glitch-free function output
//   chg  : one-cycle pulse on every change of f
//   busy : a candidate change of f is being qualified
// master drives en/byp/in and observes f/chg/busy; slave is the filter side.
interface glitch_free_func_if #(
    parameter int unsigned N = 4
) ();
    logic         en;
    logic         byp;
    logic [N-1:0] in;
    logic         f;
    logic         chg;
    logic         busy;

    modport master (output en, byp, in, input f, chg, busy);
    modport slave  (input en, byp, in, output f, chg, busy);
endinterface

// File: rtl/glitch_free_func.sv
// Glitch-free combinational function of asynchronous inputs.
// The inputs are synchronised through a SYNC-deep flop chain, looked up in
// TRUTH, and the result only reaches f after it has disagreed with f for
// STABLE consecutive edges (or immediately in bypass mode).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : glitch_free_func_if slave (en, byp, in -> f, chg, busy)
module glitch_free_func #(
    parameter int unsigned         N      = 4,
    parameter logic [(1<<N)-1:0]   TRUTH  = 16'h3F75,
    parameter int unsigned         SYNC   = 2,
    parameter int unsigned         STABLE = 3
) (
    input logic               clk,
    input logic               rst,
    glitch_free_func_if.slave bus
);
    localparam int unsigned   CW     = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CntMax = CW'(STABLE - 1);

    logic [N-1:0]  sync_q [SYNC];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          f_q, f_d;
    logic          chg_q, chg_d;
    logic          raw;

    assign raw = TRUTH[sync_q[SYNC-1]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) begin
                sync_q[i] <= '0;
            end
            cnt_q <= '0;
            f_q   <= TRUTH[0];
            chg_q <= 1'b0;
        end else begin
            sync_q[0] <= bus.in;
            for (int i = 1; i < SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            cnt_q <= cnt_d;
            f_q   <= f_d;
            chg_q <= chg_d;
        end
    end

    // Any edge that does not extend a disagreement streak clears cnt, so
    // disable, bypass and a reverting raw all restart qualification.
    always_comb begin
        cnt_d = '0;
        f_d   = f_q;
        chg_d = 1'b0;
        if (bus.en) begin
            if (bus.byp) begin
                f_d   = raw;
                chg_d = (raw != f_q);
            end else if (raw != f_q) begin
                if (cnt_q == CntMax) begin
                    f_d   = raw;
                    chg_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    assign bus.f    = f_q;
    assign bus.chg  = chg_q;
    assign bus.busy = bus.en & ~bus.byp & (raw != f_q);
endmodule

// File: tb/tb_glitch_free_func.sv
// Self-checking bench for glitch_free_func with default parameters.
module tb_glitch_free_func;
    localparam int unsigned N      = 4;
    localparam logic [15:0] TRUTH  = 16'h3F75;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glitch_free_func_if #(.N(N)) bus ();

    glitch_free_func #(
        .N      (N),
        .TRUTH  (TRUTH),
        .SYNC   (SYNC),
        .STABLE (STABLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: history of sampled inputs, a disagreement streak length.
    logic [N-1:0] m_hist[$];
    logic         m_f      = 1'b1;
    logic         m_chg    = 1'b0;
    int           m_streak = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_raw();
        return TRUTH[m_hist[SYNC-1]];
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic b, input logic [N-1:0] v);
        logic raw;
        logic old_f;
        if (r) begin
            m_hist.delete();
            for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
            m_f      = TRUTH[0];
            m_chg    = 1'b0;
            m_streak = 0;
            return;
        end
        raw   = m_raw();
        old_f = m_f;
        m_chg = 1'b0;
        if (!e) begin
            m_streak = 0;
        end else if (b) begin
            m_f      = raw;
            m_chg    = (raw != old_f);
            m_streak = 0;
        end else if (raw != m_f) begin
            m_streak = m_streak + 1;
            if (m_streak == STABLE) begin
                m_f      = raw;
                m_chg    = 1'b1;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
        m_hist.push_front(v);
        void'(m_hist.pop_back());
    endtask

    // One clock edge: model follows the inputs present at the edge, then all
    // outputs are compared 1 time unit later.
    task automatic tick();
        logic         r = rst;
        logic         e = bus.en;
        logic         b = bus.byp;
        logic [N-1:0] v = bus.in;
        @(posedge clk);
        model_edge(r, e, b, v);
        #1;
        check("f", bus.f, m_f);
        check("chg", bus.chg, m_chg);
        check("busy", bus.busy, bus.en & ~bus.byp & (m_raw() != m_f));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
        bus.en  = 1'b1;
        bus.byp = 1'b0;
        bus.in  = 4'b0000;
        rst     = 1'b1;

        // Reset and idle with in=0.
        ticks(2);
        check("reset_f", bus.f, 1'b1);
        check("reset_chg", bus.chg, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        rst = 1'b0;
        ticks(10);
        check("idle_f", bus.f, 1'b1);

        // Held change 0000->0001: f falls on the 5th edge with one chg.
        bus.in = 4'b0001;
        ticks(4);
        check("lat_before_f", bus.f, 1'b1);
        ticks(1);
        check("lat_edge_f", bus.f, 1'b0);
        check("lat_edge_chg", bus.chg, 1'b1);
        ticks(1);
        check("lat_after_chg", bus.chg, 1'b0);
        check("lat_after_busy", bus.busy, 1'b0);

        // Back to 1 and settle.
        bus.in = 4'b0000;
        ticks(8);
        check("settle_f", bus.f, 1'b1);

        // Short pulse must be filtered.
        bus.in = 4'b0001;
        ticks(2);
        bus.in = 4'b0000;
        ticks(6);
        check("pulse_f", bus.f, 1'b1);

        // Static-1 toggling never disturbs f.
        for (int i = 0; i < 20; i++) begin
            bus.in = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            tick();
            check("static_chg", bus.chg, 1'b0);
        end
        bus.in = 4'b0000;
        ticks(3);

        // Bypass: f follows on the SYNC+1 edge.
        bus.byp = 1'b1;
        bus.in  = 4'b0001;
        ticks(2);
        check("byp_before_f", bus.f, 1'b1);
        ticks(1);
        check("byp_edge_f", bus.f, 1'b0);
        check("byp_edge_chg", bus.chg, 1'b1);
        bus.in = 4'b0000;
        ticks(3);
        check("byp_back_f", bus.f, 1'b1);
        check("byp_back_chg", bus.chg, 1'b1);
        ticks(1);
        check("byp_quiet_chg", bus.chg, 1'b0);
        bus.byp = 1'b0;
        ticks(2);

        // Disable mid-qualification, then re-enable: restart from zero.
        bus.in = 4'b0001;
        ticks(4);
        bus.en = 1'b0;
        ticks(4);
        check("dis_f", bus.f, 1'b1);
        bus.en = 1'b1;
        ticks(2);
        check("reen_before_f", bus.f, 1'b1);
        ticks(1);
        check("reen_edge_f", bus.f, 1'b0);

        // Same with reset pulsed instead of en.
        bus.in = 4'b0000;
        ticks(6);
        bus.in = 4'b0001;
        ticks(4);
        rst = 1'b1;
        ticks(1);
        check("rst_mid_f", bus.f, 1'b1);
        rst = 1'b0;
        ticks(SYNC + STABLE - 1);
        check("rst_before_f", bus.f, 1'b1);
        ticks(1);
        check("rst_edge_f", bus.f, 1'b0);

        // Randomised segments against the model.
        for (int s = 0; s < 120; s++) begin
            bus.in  = N'($urandom_range(0, 15));
            bus.en  = ($urandom_range(0, 9) != 0);
            bus.byp = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 29) == 0);
            ticks(1);
            rst = 1'b0;
            ticks($urandom_range(0, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
